// File: rtl/fpnew_opgroup_out_fifo.sv
// Elastic output FIFO placed behind an FPU operation group. It also accumulates
// sticky exception flags over every result handed downstream.
package fpnew_pkg;
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

module fpnew_opgroup_out_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 2,
  parameter type         TagType  = logic,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Width-1:0]    result_i,
  input  fpnew_pkg::status_t  status_i,
  input  logic                extension_bit_i,
  input  TagType              tag_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    result_o,
  output fpnew_pkg::status_t  status_o,
  output logic                extension_bit_o,
  output TagType              tag_o,
  output fpnew_pkg::status_t  fflags_o,
  input  logic                fflags_clr_i,
  output logic [CntWidth-1:0] count_o,
  output logic                busy_o
);

  localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

  logic [Width-1:0]   r_result [Depth];
  fpnew_pkg::status_t r_status [Depth];
  logic               r_ext    [Depth];
  TagType             r_tag    [Depth];

  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;
  logic [CntWidth-1:0] w_count_next;
  logic                r_busy;
  fpnew_pkg::status_t  r_fflags;
  fpnew_pkg::status_t  w_fflags_next;
  fpnew_pkg::status_t  w_pop_status;
  logic                w_push;
  logic                w_pop;

  // Pointers step through 0..Depth-1 and wrap explicitly, so any Depth works.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // A full buffer never accepts alongside a pop: in_ready ignores out_ready_i.
  assign in_ready_o  = (r_count < DepthCnt) & ~flush_i & ~rst_i;
  assign out_valid_o = (r_count != '0) & ~flush_i & ~rst_i;
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  assign result_o        = r_result[r_rd_ptr];
  assign status_o        = r_status[r_rd_ptr];
  assign extension_bit_o = r_ext[r_rd_ptr];
  assign tag_o           = r_tag[r_rd_ptr];
  assign fflags_o        = r_fflags;
  assign count_o         = r_count;
  assign busy_o          = r_busy;

  // Next occupancy and next sticky flags.
  always_comb begin
    w_count_next  = r_count;
    w_pop_status  = '0;
    w_fflags_next = r_fflags;
    if (w_pop) begin
      w_pop_status = status_o;
    end else begin
      w_pop_status = '0;
    end
    if (flush_i) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CntWidth'(1);
        2'b01:   w_count_next = r_count - CntWidth'(1);
        default: w_count_next = r_count;
      endcase
    end
    if (fflags_clr_i) begin
      w_fflags_next = w_pop_status;
    end else begin
      w_fflags_next = fpnew_pkg::status_t'(r_fflags | w_pop_status);
    end
  end

  // Entry storage, cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        r_result[i] <= '0;
        r_status[i] <= '0;
        r_ext[i]    <= 1'b0;
        r_tag[i]    <= '0;
      end
    end else if (w_push) begin
      r_result[r_wr_ptr] <= result_i;
      r_status[r_wr_ptr] <= status_i;
      r_ext[r_wr_ptr]    <= extension_bit_i;
      r_tag[r_wr_ptr]    <= tag_i;
    end
  end

  // Pointers, occupancy, busy and sticky flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_fflags <= '0;
    end else begin
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count  <= w_count_next;
      r_busy   <= (w_count_next != '0);
      r_fflags <= w_fflags_next;
    end
  end

endmodule

// File: tb/tb_fpnew_opgroup_out_fifo.sv
// Bench for fpnew_opgroup_out_fifo: a Depth=2 and a Depth=3 instance checked
// every cycle against a queue-based reference model.
module tb_fpnew_opgroup_out_fifo;
  typedef logic [3:0] tag_t;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  st;
    logic        ext;
    tag_t        tag;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic               rst [2];
  logic               in_valid [2];
  logic               in_ready [2];
  logic               flush [2];
  logic               out_valid [2];
  logic               out_ready [2];
  logic               fclr [2];
  logic               ext_i [2];
  logic               ext_o [2];
  logic               busy [2];
  logic [31:0]        res_i [2];
  logic [31:0]        res_o [2];
  fpnew_pkg::status_t st_i [2];
  fpnew_pkg::status_t st_o [2];
  fpnew_pkg::status_t ff_o [2];
  tag_t               tag_i [2];
  tag_t               tag_o [2];
  logic [1:0]         cnt_o [2];

  ent_t       src [2][$];
  ent_t       mq [2][$];
  logic [4:0] mf [2];
  int         seen [2];

  fpnew_opgroup_out_fifo #(.Width(32), .Depth(2), .TagType(tag_t)) u_dut2 (
    .clk_i(clk), .rst_i(rst[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .result_i(res_i[0]), .status_i(st_i[0]), .extension_bit_i(ext_i[0]), .tag_i(tag_i[0]),
    .flush_i(flush[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .result_o(res_o[0]), .status_o(st_o[0]), .extension_bit_o(ext_o[0]), .tag_o(tag_o[0]),
    .fflags_o(ff_o[0]), .fflags_clr_i(fclr[0]), .count_o(cnt_o[0]), .busy_o(busy[0])
  );

  fpnew_opgroup_out_fifo #(.Width(32), .Depth(3), .TagType(tag_t)) u_dut3 (
    .clk_i(clk), .rst_i(rst[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .result_i(res_i[1]), .status_i(st_i[1]), .extension_bit_i(ext_i[1]), .tag_i(tag_i[1]),
    .flush_i(flush[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .result_o(res_o[1]), .status_o(st_o[1]), .extension_bit_o(ext_o[1]), .tag_o(tag_o[1]),
    .fflags_o(ff_o[1]), .fflags_clr_i(fclr[1]), .count_o(cnt_o[1]), .busy_o(busy[1])
  );

  function automatic int dep(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic ent_t mk(input logic [31:0] r, input logic [4:0] s, input tag_t t);
    ent_t e;
    e.res = r;
    e.st  = s;
    e.ext = r[0];
    e.tag = t;
    return e;
  endfunction

  function automatic ent_t mk_rand();
    return mk($urandom, 5'($urandom_range(31, 0)), 4'($urandom_range(15, 0)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare one instance against the model, then advance the model by one edge.
  task automatic step(input int d);
    bit         exp_ir;
    bit         exp_ov;
    logic [4:0] pst;
    exp_ir = !rst[d] && !flush[d] && (mq[d].size() < dep(d));
    exp_ov = !rst[d] && !flush[d] && (mq[d].size() != 0);
    chk($sformatf("d%0d in_ready", d), in_ready[d], exp_ir);
    chk($sformatf("d%0d out_valid", d), out_valid[d], exp_ov);
    chk($sformatf("d%0d count", d), cnt_o[d], mq[d].size());
    chk($sformatf("d%0d busy", d), busy[d], mq[d].size() != 0);
    chk($sformatf("d%0d fflags", d), ff_o[d], mf[d]);
    if (exp_ov) begin
      chk($sformatf("d%0d head_result", d), res_o[d], mq[d][0].res);
      chk($sformatf("d%0d head_status", d), st_o[d], mq[d][0].st);
      chk($sformatf("d%0d head_ext", d), ext_o[d], mq[d][0].ext);
      chk($sformatf("d%0d head_tag", d), tag_o[d], mq[d][0].tag);
    end
    if (out_valid[d] === 1'b1 && out_ready[d]) seen[d]++;
    if (rst[d]) begin
      mq[d].delete();
      mf[d] = 5'h00;
    end else if (flush[d]) begin
      mq[d].delete();
    end else begin
      pst = 5'h00;
      if (exp_ov && out_ready[d]) begin
        pst = mq[d][0].st;
        void'(mq[d].pop_front());
      end
      if (in_valid[d] && exp_ir) begin
        mq[d].push_back(src[d][0]);
        void'(src[d].pop_front());
      end
      mf[d] = fclr[d] ? pst : (mf[d] | pst);
    end
  endtask

  task automatic do_cycle();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = (src[d].size() != 0);
      if (in_valid[d]) begin
        res_i[d] = src[d][0].res;
        st_i[d]  = fpnew_pkg::status_t'(src[d][0].st);
        ext_i[d] = src[d][0].ext;
        tag_i[d] = src[d][0].tag;
      end else begin
        res_i[d] = $urandom;
        st_i[d]  = fpnew_pkg::status_t'(5'($urandom_range(31, 0)));
        ext_i[d] = 1'($urandom_range(1, 0));
        tag_i[d] = 4'($urandom_range(15, 0));
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int d, input int budget);
    int n;
    n = 0;
    out_ready[d] = 1'b1;
    while ((src[d].size() != 0 || mq[d].size() != 0) && n < budget) begin
      do_cycle();
      n++;
    end
    do_cycle();
    chk($sformatf("d%0d idle_count", d), cnt_o[d], 2'd0);
    chk($sformatf("d%0d idle_busy", d), busy[d], 1'b0);
  endtask

  initial begin
    logic [4:0] ff_before;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; flush[d] = 1'b0; out_ready[d] = 1'b0; fclr[d] = 1'b0;
      in_valid[d] = 1'b1; res_i[d] = 32'h0; st_i[d] = '0; ext_i[d] = 1'b0; tag_i[d] = 4'h0;
      mf[d] = 5'h00; seen[d] = 0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst in_ready_d2", in_ready[0], 1'b0);
    chk("rst in_ready_d3", in_ready[1], 1'b0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    chk("rst_val in_ready", in_ready[0], 1'b1);
    chk("rst_val out_valid", out_valid[0], 1'b0);
    chk("rst_val result", res_o[0], 32'h0);
    chk("rst_val status", st_o[0], 5'h00);
    chk("rst_val ext", ext_o[0], 1'b0);
    chk("rst_val tag", tag_o[0], 4'h0);
    chk("rst_val fflags", ff_o[0], 5'h00);
    chk("rst_val count", cnt_o[0], 2'd0);
    chk("rst_val busy", busy[0], 1'b0);

    // Basic flow.
    src[0].push_back(mk(32'h3F800000, 5'h01, 4'h1));
    out_ready[0] = 1'b1;
    do_cycle();
    chk("basic out_valid", out_valid[0], 1'b1);
    chk("basic result", res_o[0], 32'h3F800000);
    chk("basic tag", tag_o[0], 4'h1);
    run_idle(0, 10);
    chk("basic fflags", ff_o[0], 5'h01);

    // Full / backpressure: A, B accepted, C held until the cycle after a pop.
    out_ready[0] = 1'b0;
    src[0].push_back(mk(32'hAAAA0001, 5'h00, 4'hA));
    src[0].push_back(mk(32'hBBBB0002, 5'h00, 4'hB));
    src[0].push_back(mk(32'hCCCC0003, 5'h00, 4'hC));
    repeat (4) do_cycle();
    chk("full count", cnt_o[0], 2'd2);
    chk("full in_ready", in_ready[0], 1'b0);
    out_ready[0] = 1'b1;
    do_cycle();
    chk("full c_not_yet", src[0].size(), 1);
    run_idle(0, 10);

    // Wrap-around on Depth=3 with toggling out_ready.
    for (int i = 0; i < 10; i++) src[1].push_back(mk_rand());
    seen[1] = 0;
    for (int i = 0; i < 60 && (src[1].size() != 0 || mq[1].size() != 0); i++) begin
      out_ready[1] = ~out_ready[1];
      do_cycle();
    end
    chk("wrap delivered", seen[1], 10);
    run_idle(1, 10);

    // Flush: two buffered, flush with a valid input.
    out_ready[0] = 1'b0;
    src[0].push_back(mk(32'h11110000, 5'h02, 4'h3));
    src[0].push_back(mk(32'h22220000, 5'h02, 4'h4));
    repeat (2) do_cycle();
    ff_before = mf[0];
    src[0].push_back(mk(32'h33330000, 5'h04, 4'h5));
    flush[0] = 1'b1;
    do_cycle();
    flush[0] = 1'b0;
    src[0].delete();
    chk("flush count", cnt_o[0], 2'd0);
    chk("flush out_valid", out_valid[0], 1'b0);
    chk("flush fflags", ff_o[0], ff_before);
    do_cycle();

    // Sticky flags and clear-with-pop.
    fclr[0] = 1'b1;
    do_cycle();
    fclr[0] = 1'b0;
    src[0].push_back(mk(32'h44440000, 5'h04, 4'h6));
    src[0].push_back(mk(32'h55550000, 5'h08, 4'h7));
    run_idle(0, 10);
    chk("sticky of_dz", ff_o[0], 5'h0C);
    out_ready[0] = 1'b0;
    src[0].push_back(mk(32'h66660000, 5'h10, 4'h8));
    do_cycle();
    out_ready[0] = 1'b1;
    fclr[0] = 1'b1;
    do_cycle();
    fclr[0] = 1'b0;
    out_ready[0] = 1'b0;
    do_cycle();
    chk("sticky clr_pop", ff_o[0], 5'h10);

    // Randomized traffic on Depth=2.
    for (int i = 0; i < 40; i++) src[0].push_back(mk_rand());
    for (int i = 0; i < 300 && src[0].size() != 0; i++) begin
      out_ready[0] = 1'($urandom_range(1, 0));
      fclr[0]      = ($urandom_range(7, 0) == 0);
      flush[0]     = ($urandom_range(15, 0) == 0);
      do_cycle();
    end
    fclr[0] = 1'b0;
    flush[0] = 1'b0;
    run_idle(0, 10);

    // Reset mid-operation: flags at 0x1F, two entries buffered.
    src[0].push_back(mk(32'h77770000, 5'h1F, 4'h9));
    run_idle(0, 10);
    out_ready[0] = 1'b0;
    src[0].push_back(mk(32'h88880001, 5'h01, 4'hD));
    src[0].push_back(mk(32'h99990001, 5'h02, 4'hE));
    repeat (2) do_cycle();
    chk("mid_rst fflags_pre", ff_o[0], 5'h1F);
    src[0].push_back(mk(32'hEEEE0001, 5'h03, 4'hF));
    rst[0] = 1'b1;
    do_cycle();
    rst[0] = 1'b0;
    src[0].delete();
    in_valid[0] = 1'b0;
    #1;
    chk("mid_rst in_ready", in_ready[0], 1'b1);
    chk("mid_rst out_valid", out_valid[0], 1'b0);
    chk("mid_rst result", res_o[0], 32'h0);
    chk("mid_rst status", st_o[0], 5'h00);
    chk("mid_rst ext", ext_o[0], 1'b0);
    chk("mid_rst tag", tag_o[0], 4'h0);
    chk("mid_rst fflags", ff_o[0], 5'h00);
    chk("mid_rst count", cnt_o[0], 2'd0);
    chk("mid_rst busy", busy[0], 1'b0);
    repeat (2) do_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
